mem_port_arbiter: RTL and testbench

- Shares the processor's single-port data/program memory between two requesters: the control-unit datapath (CPU port: opcode/operand fetch, LDA/LDB direct loads, STA/STB stores) and the external port (program loader / IO DMA).
- Each requester runs one transaction at a time with a req/ack handshake.
- The arbiter serialises transactions, drives the memory pins, returns read data, and gives the control unit a stall signal so its FSM holds state until its access completes.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 39 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter and its grant picker.
package mem_arb_pkg;

  localparam int ARB_AW = 8;
  localparam int ARB_DW = 8;

  typedef enum logic [3:0] {
    ARB_IDLE  = 4'b0001,
    ARB_ISSUE = 4'b0010,
    ARB_WAIT  = 4'b0100,
    ARB_RESP  = 4'b1000
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  // Countdown preload for the WAIT state; a latency of 1 means zero extra wait cycles.
  function automatic logic [1:0] wait_preload(input int read_lat);
    return 2'(read_lat - 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester winner selection: fixed CPU priority or alternate against the last grant.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int CPU_PRIO = 0
)(
  input  logic cpu_req,
  input  logic ext_req,
  input  logic last_gnt,
  output logic gnt_id,
  output logic gnt_valid
);

  // Winner and valid flag from the current requests.
  always_comb begin
    gnt_id    = OWN_CPU;
    gnt_valid = 1'b0;
    if (cpu_req && ext_req) begin
      gnt_valid = 1'b1;
      if (CPU_PRIO != 0) begin
        gnt_id = OWN_CPU;
      end else if (last_gnt == OWN_CPU) begin
        gnt_id = OWN_EXT;
      end else begin
        gnt_id = OWN_CPU;
      end
    end else if (cpu_req) begin
      gnt_valid = 1'b1;
      gnt_id    = OWN_CPU;
    end else if (ext_req) begin
      gnt_valid = 1'b1;
      gnt_id    = OWN_EXT;
    end else begin
      gnt_valid = 1'b0;
      gnt_id    = OWN_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and external-port transactions onto the single-port memory,
// returning read data and a combinational stall to the control unit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int READ_LAT = 1,
  parameter int CPU_PRIO = 0
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
      $error("mem_port_arbiter: READ_LAT must be within 1..4");
    end
  endgenerate

  localparam logic [1:0] WAIT_INIT = wait_preload(READ_LAT);

  arb_state_t    state_r, next_state_s;
  logic          last_gnt_r, owner_r;
  logic          gnt_id_s, gnt_valid_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic [1:0]    wait_cnt_r;
  logic          mem_en_r, mem_we_r, busy_r, cpu_ack_r, ext_ack_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r, cpu_rdata_r, ext_rdata_r;

  rr_pick2 #(.CPU_PRIO(CPU_PRIO)) u_pick (
    .cpu_req   (cpu_req),
    .ext_req   (ext_req),
    .last_gnt  (last_gnt_r),
    .gnt_id    (gnt_id_s),
    .gnt_valid (gnt_valid_s)
  );

  // Next-state logic; a write leaves ISSUE straight for RESP.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (gnt_valid_s) next_state_s = ARB_ISSUE;
        else             next_state_s = ARB_IDLE;
      end
      ARB_ISSUE: begin
        if (mem_we_r) next_state_s = ARB_RESP;
        else          next_state_s = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (wait_cnt_r == 2'd0) next_state_s = ARB_RESP;
        else                    next_state_s = ARB_WAIT;
      end
      ARB_RESP: next_state_s = ARB_IDLE;
      default:  next_state_s = ARB_IDLE;
    endcase
  end

  // Transaction fields of the port that wins this cycle.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt_id_s == OWN_CPU) begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end else begin
      sel_we_s    = ext_we;
      sel_addr_s  = ext_addr;
      sel_wdata_s = ext_wdata;
    end
  end

  // State, memory pins, acks and read-data registers; outputs follow the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ARB_IDLE;
      last_gnt_r  <= OWN_EXT;
      owner_r     <= OWN_CPU;
      wait_cnt_r  <= 2'd0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      cpu_ack_r   <= 1'b0;
      ext_ack_r   <= 1'b0;
      cpu_rdata_r <= '0;
      ext_rdata_r <= '0;
    end else begin
      state_r   <= next_state_s;
      mem_en_r  <= (next_state_s == ARB_ISSUE);
      mem_we_r  <= (next_state_s == ARB_ISSUE) && sel_we_s;
      busy_r    <= (next_state_s != ARB_IDLE);
      cpu_ack_r <= (next_state_s == ARB_RESP) && (owner_r == OWN_CPU);
      ext_ack_r <= (next_state_s == ARB_RESP) && (owner_r == OWN_EXT);
      case (state_r)
        ARB_IDLE: begin
          if (gnt_valid_s) begin
            owner_r     <= gnt_id_s;
            last_gnt_r  <= gnt_id_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
          end
        end
        ARB_ISSUE: wait_cnt_r <= WAIT_INIT;
        ARB_WAIT: begin
          if (wait_cnt_r == 2'd0) begin
            if (owner_r == OWN_CPU) cpu_rdata_r <= mem_rdata;
            else                    ext_rdata_r <= mem_rdata;
          end else begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack_r;
  assign cpu_ack   = cpu_ack_r;
  assign ext_ack   = ext_ack_r;
  assign cpu_rdata = cpu_rdata_r;
  assign ext_rdata = ext_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Three arbiter instances (round-robin/lat 1, CPU priority/lat 1, round-robin/lat 3)
// each with a bench memory; acks are scored against a queue of expected completions.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]       cpu_req, cpu_we, ext_req, ext_we;
  logic [2:0][7:0]  cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [2:0]       cpu_ack, cpu_stall, ext_ack, mem_en, mem_we, busy;
  logic [2:0][7:0]  cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int         dut;
    logic       port;
    logic       is_read;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int RL = (g == 2) ? 3 : 1;
      localparam int PR = (g == 1) ? 1 : 0;
      logic [7:0] mem [256];
      logic [7:0] pipe [4];
      exp_t       e;

      mem_port_arbiter #(.AW(8), .DW(8), .READ_LAT(RL), .CPU_PRIO(PR)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req[g]),
        .cpu_we    (cpu_we[g]),
        .cpu_addr  (cpu_addr[g]),
        .cpu_wdata (cpu_wdata[g]),
        .cpu_ack   (cpu_ack[g]),
        .cpu_rdata (cpu_rdata[g]),
        .cpu_stall (cpu_stall[g]),
        .ext_req   (ext_req[g]),
        .ext_we    (ext_we[g]),
        .ext_addr  (ext_addr[g]),
        .ext_wdata (ext_wdata[g]),
        .ext_ack   (ext_ack[g]),
        .ext_rdata (ext_rdata[g]),
        .mem_en    (mem_en[g]),
        .mem_we    (mem_we[g]),
        .mem_addr  (mem_addr[g]),
        .mem_wdata (mem_wdata[g]),
        .mem_rdata (mem_rdata[g]),
        .busy      (busy[g])
      );

      initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h4A;
        for (int i = 0; i < 4; i++) pipe[i] = 8'hEE;
      end

      // Memory: data only valid exactly RL cycles after the enable cycle.
      always @(posedge clock) begin
        if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
        pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 8'hEE;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = pipe[RL-1];

      always @(negedge clock) begin
        if (reset && (cpu_ack[g] || ext_ack[g])) begin
          chk("ack_overlap", 32'(cpu_ack[g] & ext_ack[g]), 32'd0);
          chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_dut", 32'(g), 32'(e.dut));
            chk("ack_port", 32'(ext_ack[g]), 32'(e.port));
            if (e.is_read)
              chk("rdata", 32'(ext_ack[g] ? ext_rdata[g] : cpu_rdata[g]), 32'(e.rdata));
          end
        end
      end
    end
  endgenerate

  task automatic step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = '0; ext_we = '0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic push(input int k, input logic port, input logic rd, input logic [7:0] val);
    exp_t x;
    x.dut = k; x.port = port; x.is_read = rd; x.rdata = val;
    exp_q.push_back(x);
  endtask

  task automatic start(input int k, input logic port, input logic we, input logic [7:0] a,
                       input logic [7:0] d);
    if (port == OWN_CPU) begin
      cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d; cpu_req[k] = 1'b1;
    end else begin
      ext_we[k] = we; ext_addr[k] = a; ext_wdata[k] = d; ext_req[k] = 1'b1;
    end
  endtask

  task automatic wait_ack(input int k, input logic port);
    logic done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if ((port == OWN_CPU) ? cpu_ack[k] : ext_ack[k]) begin
        done = 1'b1;
        if (port == OWN_CPU) cpu_req[k] = 1'b0;
        else                 ext_req[k] = 1'b0;
      end
    end
    chk("ack_timeout", 32'(done), 32'd1);
  endtask

  // Both ports keep requesting until each has its quota of acks.
  task automatic run_both(input int k, input int ncpu, input int next, input int gap);
    int cc = 0, ec = 0, cyc = 0, last = -1;
    cpu_req[k] = 1'b1; ext_req[k] = 1'b1;
    while ((cc < ncpu || ec < next) && cyc < 200) begin
      step(); cyc++;
      if (cpu_ack[k] || ext_ack[k]) begin
        if (last >= 0) chk("ack_gap", 32'(cyc - last), 32'(gap));
        last = cyc;
      end
      if (cpu_ack[k]) begin cc++; if (cc >= ncpu) cpu_req[k] = 1'b0; end
      if (ext_ack[k]) begin ec++; if (ec >= next) ext_req[k] = 1'b0; end
    end
    chk("cpu_quota", 32'(cc), 32'(ncpu));
    chk("ext_quota", 32'(ec), 32'(next));
    cpu_req[k] = 1'b0; ext_req[k] = 1'b0;
  endtask

  task automatic chk_zero(input int k);
    chk("rst_busy", 32'(busy[k]), 32'd0);
    chk("rst_mem_en", 32'(mem_en[k]), 32'd0);
    chk("rst_mem_we", 32'(mem_we[k]), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata[k]), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack[k]), 32'd0);
    chk("rst_ext_ack", 32'(ext_ack[k]), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata[k]), 32'd0);
    chk("rst_ext_rdata", 32'(ext_rdata[k]), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall[k]), 32'd0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 3; k++) chk_zero(k);
    reset = 1'b1;
    step();

    // Single CPU read of 0x10 (0x5A), latency 1.
    start(0, OWN_CPU, 1'b0, 8'h10, 8'h00);
    push(0, OWN_CPU, 1'b1, 8'h5A);
    #1;
    chk("rd_stall_t0", 32'(cpu_stall[0]), 32'd1);
    step();
    chk("rd_mem_en_t1", 32'(mem_en[0]), 32'd1);
    chk("rd_mem_we_t1", 32'(mem_we[0]), 32'd0);
    chk("rd_mem_addr_t1", 32'(mem_addr[0]), 32'h10);
    chk("rd_stall_t1", 32'(cpu_stall[0]), 32'd1);
    step();
    chk("rd_mem_en_t2", 32'(mem_en[0]), 32'd0);
    chk("rd_stall_t2", 32'(cpu_stall[0]), 32'd1);
    step();
    chk("rd_ack_t3", 32'(cpu_ack[0]), 32'd1);
    chk("rd_stall_t3", 32'(cpu_stall[0]), 32'd0);
    cpu_req[0] = 1'b0;
    step();
    chk("rd_ack_t4", 32'(cpu_ack[0]), 32'd0);
    chk("rd_busy_t4", 32'(busy[0]), 32'd0);
    chk("rd_rdata_held", 32'(cpu_rdata[0]), 32'h5A);
    chk("rd_addr_held", 32'(mem_addr[0]), 32'h10);

    // External write 0x3C to 0x20, then CPU reads it back.
    start(0, OWN_EXT, 1'b1, 8'h20, 8'h3C);
    push(0, OWN_EXT, 1'b0, 8'h00);
    step();
    chk("wr_mem_en_t1", 32'(mem_en[0]), 32'd1);
    chk("wr_mem_we_t1", 32'(mem_we[0]), 32'd1);
    chk("wr_mem_addr_t1", 32'(mem_addr[0]), 32'h20);
    chk("wr_mem_wdata_t1", 32'(mem_wdata[0]), 32'h3C);
    step();
    chk("wr_ack_t2", 32'(ext_ack[0]), 32'd1);
    chk("wr_mem_we_t2", 32'(mem_we[0]), 32'd0);
    ext_req[0] = 1'b0;
    step();
    start(0, OWN_CPU, 1'b0, 8'h20, 8'h00);
    push(0, OWN_CPU, 1'b1, 8'h3C);
    wait_ack(0, OWN_CPU);
    step();
    chk("rb_cpu_rdata", 32'(cpu_rdata[0]), 32'h3C);
    chk("rb_ext_rdata_untouched", 32'(ext_rdata[0]), 32'd0);

    // Round-robin tie from reset: CPU, EXT, CPU, EXT.
    do_reset();
    cpu_addr[0] = 8'h01; ext_addr[0] = 8'h02;
    push(0, OWN_CPU, 1'b1, 8'h4B);
    push(0, OWN_EXT, 1'b1, 8'h48);
    push(0, OWN_CPU, 1'b1, 8'h4B);
    push(0, OWN_EXT, 1'b1, 8'h48);
    run_both(0, 2, 2, 4);
    step(); step();
    chk("rr_busy_after", 32'(busy[0]), 32'd0);
    chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // Fixed CPU priority: three CPU transactions before EXT gets in.
    do_reset();
    cpu_addr[1] = 8'h05; ext_addr[1] = 8'h06;
    push(1, OWN_CPU, 1'b1, 8'h4F);
    push(1, OWN_CPU, 1'b1, 8'h4F);
    push(1, OWN_CPU, 1'b1, 8'h4F);
    push(1, OWN_EXT, 1'b1, 8'h4C);
    run_both(1, 3, 1, 4);
    step();
    chk("prio_queue_drained", 32'(exp_q.size()), 32'd0);

    // Read latency 3: ack at T+5, enable only at T+1, busy T+1..T+5.
    do_reset();
    start(2, OWN_CPU, 1'b0, 8'h33, 8'h00);
    push(2, OWN_CPU, 1'b1, 8'h79);
    chk("rl3_busy_t0", 32'(busy[2]), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("rl3_mem_en", 32'(mem_en[2]), 32'(i == 1));
      chk("rl3_busy", 32'(busy[2]), 32'd1);
      chk("rl3_ack", 32'(cpu_ack[2]), 32'(i == 5));
    end
    cpu_req[2] = 1'b0;
    step();
    chk("rl3_busy_t6", 32'(busy[2]), 32'd0);
    chk("rl3_rdata", 32'(cpu_rdata[2]), 32'h79);

    // Reset while in WAIT: abandoned, then CPU wins the first tie.
    start(2, OWN_CPU, 1'b0, 8'h34, 8'h00);
    step(); step();
    chk("mid_busy_wait", 32'(busy[2]), 32'd1);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk_zero(2);
    step(); step();
    chk("mid_no_ack", 32'(cpu_ack[2]), 32'd0);
    reset = 1'b1;
    step();
    cpu_addr[2] = 8'h34; ext_addr[2] = 8'h35;
    push(2, OWN_CPU, 1'b1, 8'h7E);
    push(2, OWN_EXT, 1'b1, 8'h7F);
    run_both(2, 1, 1, 6);
    step(); step();
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
